// File: rtl/convert_uns_to_float_pkg.sv
// -----------------------------------------------------------------------------
// convert_uns_to_float_pkg
// Shared FP definitions for the unsigned-integer -> binary32 converter:
// rounding-mode encodings, fflags bit positions, binary32 field widths and
// bias, and the rounding-increment decision used by the rounder stage.
// -----------------------------------------------------------------------------
package convert_uns_to_float_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam logic [FP32_EXP_W-1:0] FP32_BIAS = 8'd127;

    typedef enum logic [2:0] {
        FRM_RNE = 3'b000,
        FRM_RTZ = 3'b001,
        FRM_RDN = 3'b010,
        FRM_RUP = 3'b011,
        FRM_RMM = 3'b100
    } frm_e;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    // Round-up decision for a non-negative magnitude. RDN behaves like RTZ
    // because the operand is never negative. Reserved encodings fall back to
    // RNE; decode traps them before they reach this unit.
    function automatic logic round_up(input logic [2:0] frm,
                                      input logic       guard,
                                      input logic       sticky,
                                      input logic       lsb);
        case (frm)
            FRM_RTZ, FRM_RDN: round_up = 1'b0;
            FRM_RUP:          round_up = guard | sticky;
            FRM_RMM:          round_up = guard;
            default:          round_up = guard & (sticky | lsb);
        endcase
    endfunction

endpackage

// File: rtl/convert_uns_to_float_lzc32.sv
// -----------------------------------------------------------------------------
// convert_uns_to_float_lzc32
// Combinational 32-bit leading-zero counter.
//   i_data  in  32  operand
//   o_cnt   out 5   number of leading zeros (0..31; 0 when i_data is zero)
//   o_zero  out 1   i_data is all zeros
// -----------------------------------------------------------------------------
module lzc32 (
    input  logic [31:0] i_data,
    output logic [4:0]  o_cnt,
    output logic        o_zero
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        o_cnt  = 5'd0;
        o_zero = (i_data == 32'd0);
        // Scan upward so the most significant set bit is the last to win.
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) o_cnt = 5'(31 - i);
        end
    end

endmodule

// File: rtl/convert_uns_to_float.sv
// -----------------------------------------------------------------------------
// convert_uns_to_float
// 3-stage pipelined FCVT.S.WU: 32-bit unsigned integer -> IEEE-754 binary32.
//   S1: capture operand/frm/tag, leading-zero count and zero flag
//   S2: normalise (leading one to bit 31), unbiased exponent
//   S3: round, pack, flags (output register)
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flush                            kill all in-flight ops (beats handshakes)
//   in_valid/in_ready                input handshake
//   in_int[31:0], in_frm[2:0], in_tag operand, rounding mode, opaque tag
//   out_valid/out_ready              output handshake
//   out_float[31:0], out_fflags[4:0], out_tag  result, {NV,DZ,OF,UF,NX}, tag
// -----------------------------------------------------------------------------
module convert_uns_to_float
    import convert_uns_to_float_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_int,
    input  logic [2:0]       in_frm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag
);

    // ---------------- stage registers ----------------
    logic             r_s1_valid, r_s2_valid, r_s3_valid;
    logic [31:0]      r_s1_int;
    logic [2:0]       r_s1_frm, r_s2_frm;
    logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
    logic             r_s1_zero, r_s2_zero;
    logic [4:0]       r_s1_lz, r_s2_exp_unb;
    logic [31:0]      r_s2_norm;
    logic [31:0]      r_s3_float;
    logic [4:0]       r_s3_fflags;

    // ---------------- handshake ----------------
    // A stage may load when it is empty or its content leaves this cycle.
    logic w_s3_free, w_s2_free, w_s1_free;
    assign w_s3_free = !r_s3_valid || out_ready;
    assign w_s2_free = !r_s2_valid || w_s3_free;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign in_ready  = w_s1_free;

    // ---------------- S1 combinational ----------------
    logic [4:0] w_lz;
    logic       w_zero;

    lzc32 u_lzc (
        .i_data (in_int),
        .o_cnt  (w_lz),
        .o_zero (w_zero)
    );

    // ---------------- S2 combinational ----------------
    logic [31:0] w_norm;
    logic [4:0]  w_exp_unb;
    assign w_norm    = r_s1_int << r_s1_lz;
    assign w_exp_unb = 5'd31 - r_s1_lz;

    // ---------------- S3 combinational ----------------
    logic [FP32_MAN_W-1:0] w_mant, w_mant_rnd;
    logic                  w_guard, w_sticky, w_rup, w_carry;
    logic [FP32_EXP_W-1:0] w_exp;
    logic [31:0]           w_float;
    logic [4:0]            w_fflags;

    assign w_mant   = r_s2_norm[30:8];
    assign w_guard  = r_s2_norm[7];
    assign w_sticky = |r_s2_norm[6:0];
    assign w_rup    = round_up(r_s2_frm, w_guard, w_sticky, w_mant[0]);
    // An all-ones mantissa rounding up wraps to zero and bumps the exponent;
    // the maximum biased exponent is 159, so overflow cannot occur.
    assign {w_carry, w_mant_rnd} = {1'b0, w_mant} + {{FP32_MAN_W{1'b0}}, w_rup};
    assign w_exp = FP32_BIAS + {3'b000, r_s2_exp_unb} + {7'd0, w_carry};

    always_comb begin
        w_float            = {1'b0, w_exp, w_mant_rnd};
        w_fflags           = 5'd0;
        w_fflags[FFLAG_NX] = w_guard | w_sticky;
        if (r_s2_zero) begin
            w_float  = 32'd0;
            w_fflags = 5'd0;
        end
    end

    // ---------------- valid pipeline ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_s1_free) r_s1_valid <= in_valid;
            if (w_s2_free) r_s2_valid <= r_s1_valid;
            if (w_s3_free) r_s3_valid <= r_s2_valid;
        end
    end

    // NOTE: interior datapath registers carry no reset; they are only ever
    // observed when qualified by their stage valid.
    always_ff @(posedge clk) begin
        if (w_s1_free && in_valid) begin
            r_s1_int  <= in_int;
            r_s1_frm  <= in_frm;
            r_s1_tag  <= in_tag;
            r_s1_zero <= w_zero;
            r_s1_lz   <= w_lz;
        end
        if (w_s2_free && r_s1_valid) begin
            r_s2_norm    <= w_norm;
            r_s2_exp_unb <= w_exp_unb;
            r_s2_frm     <= r_s1_frm;
            r_s2_tag     <= r_s1_tag;
            r_s2_zero    <= r_s1_zero;
        end
    end

    // Output register is reset so the visible result is defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_float  <= 32'd0;
            r_s3_fflags <= 5'd0;
            r_s3_tag    <= '0;
        end else if (w_s3_free && r_s2_valid) begin
            r_s3_float  <= w_float;
            r_s3_fflags <= w_fflags;
            r_s3_tag    <= r_s2_tag;
        end
    end

    assign out_valid  = r_s3_valid;
    assign out_float  = r_s3_float;
    assign out_fflags = r_s3_fflags;
    assign out_tag    = r_s3_tag;

endmodule

// File: tb/tb_convert_uns_to_float.sv
// -----------------------------------------------------------------------------
// tb_convert_uns_to_float
// Directed self-checking bench for convert_uns_to_float. Expected results are
// hand-computed binary32 constants.
// -----------------------------------------------------------------------------
module tb_convert_uns_to_float;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_int;
    logic [2:0]       in_frm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_float;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    convert_uns_to_float #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_int     (in_int),
        .in_frm     (in_frm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_float  (out_float),
        .out_fflags (out_fflags),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One isolated op with out_ready high: checks latency, result, flags, tag.
    task automatic run_op(input logic [31:0] val, input logic [2:0] frm,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_f,
                          input logic exp_nx, input string name);
        int n;
        in_int    = val;
        in_frm    = frm;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, 32'd3);
        check({name, " float"},   out_float, exp_f);
        check({name, " fflags"},  {27'd0, out_fflags}, {31'd0, exp_nx});
        check({name, " tag"},     {26'd0, out_tag}, {26'd0, tag});
        @(posedge clk); #1;
    endtask

    logic [31:0]      s_int [5];
    logic [31:0]      s_exp [5];
    logic [TAG_W-1:0] s_tag [5];

    initial begin
        int sent, recv, seen;
        logic acc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_int = '0;
        in_frm = 3'b000; in_tag = '0; out_ready = 1'b1;

        // ---- reset state ----
        #12;
        check("rst out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst out_float",  out_float, 32'd0);
        check("rst out_fflags", {27'd0, out_fflags}, 32'd0);
        check("rst out_tag",    {26'd0, out_tag}, 32'd0);
        check("rst in_ready",   {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- single conversions ----
        run_op(32'd0,        3'b000, 6'd1,  32'h0000_0000, 1'b0, "zero rne");
        run_op(32'd0,        3'b011, 6'd2,  32'h0000_0000, 1'b0, "zero rup");
        run_op(32'd1,        3'b000, 6'd3,  32'h3F80_0000, 1'b0, "one");
        for (int f = 0; f < 5; f++)
            run_op(32'h00FF_FFFF, 3'(f), 6'(8 + f), 32'h4B7F_FFFF, 1'b0, $sformatf("24bit frm%0d", f));
        run_op(32'h0100_0001, 3'b000, 6'd16, 32'h4B80_0000, 1'b1, "tie rne");
        run_op(32'h0100_0001, 3'b001, 6'd17, 32'h4B80_0000, 1'b1, "tie rtz");
        run_op(32'h0100_0001, 3'b010, 6'd18, 32'h4B80_0000, 1'b1, "tie rdn");
        run_op(32'h0100_0001, 3'b011, 6'd19, 32'h4B80_0001, 1'b1, "tie rup");
        run_op(32'h0100_0001, 3'b100, 6'd20, 32'h4B80_0001, 1'b1, "tie rmm");
        run_op(32'h0100_0001, 3'b111, 6'd21, 32'h4B80_0000, 1'b1, "tie rsvd");
        run_op(32'h0100_0003, 3'b000, 6'd22, 32'h4B80_0002, 1'b1, "tie rne odd");
        run_op(32'hFFFF_FFFF, 3'b000, 6'd24, 32'h4F80_0000, 1'b1, "max rne");
        run_op(32'hFFFF_FFFF, 3'b001, 6'd25, 32'h4F7F_FFFF, 1'b1, "max rtz");
        run_op(32'hFFFF_FFFF, 3'b010, 6'd26, 32'h4F7F_FFFF, 1'b1, "max rdn");
        run_op(32'hFFFF_FFFF, 3'b011, 6'd27, 32'h4F80_0000, 1'b1, "max rup");
        run_op(32'hFFFF_FFFF, 3'b100, 6'd28, 32'h4F80_0000, 1'b1, "max rmm");

        // ---- back-to-back stream under backpressure ----
        s_int = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        s_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        s_tag = '{6'd40, 6'd41, 6'd42, 6'd43, 6'd44};
        in_frm = 3'b000;
        sent = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (sent < 5);
            if (sent < 5) begin in_int = s_int[sent]; in_tag = s_tag[sent]; end
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            #1;
        end
        check("bp accepts",   sent, 32'd3);
        check("bp in_ready",  {31'd0, in_ready}, 32'd0);
        check("bp out_valid", {31'd0, out_valid}, 32'd1);
        check("bp held float", out_float, s_exp[0]);
        check("bp held tag",  {26'd0, out_tag}, {26'd0, s_tag[0]});
        out_ready = 1'b1;
        recv = 0;
        for (int c = 0; c < 30 && recv < 5; c++) begin
            in_valid = (sent < 5);
            if (sent < 5) begin in_int = s_int[sent]; in_tag = s_tag[sent]; end
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("stream float %0d", recv), out_float, s_exp[recv]);
                check($sformatf("stream tag %0d", recv), {26'd0, out_tag}, {26'd0, s_tag[recv]});
                recv++;
            end
            @(posedge clk);
            if (acc) sent++;
            #1;
        end
        in_valid = 1'b0;
        check("stream count", recv, 32'd5);
        @(posedge clk); #1;

        // ---- flush with 3 ops in flight ----
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_int = 32'd100 + 32'(i); in_tag = 6'(50 + i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("pre-flush out_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; in_int = 32'd9; in_tag = 6'd63;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush in_ready",  {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush emitted", seen, 32'd0);

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_int = 32'd7; in_tag = 6'(33 + i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre-rst out_float", out_float, 32'h40E0_0000);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid",  {31'd0, out_valid}, 32'd0);
        check("mid rst out_float",  out_float, 32'd0);
        check("mid rst out_tag",    {26'd0, out_tag}, 32'd0);
        check("mid rst in_ready",   {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h0100_0001, 3'b011, 6'd60, 32'h4B80_0001, 1'b1, "post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
